// File: rtl/bsort_run_sequencer_if.sv
// bsort_run_sequencer_if
// Groups the accelerator slave memory port (channel 0 used) and the readback
// stream into one bundle.
//   master : the run sequencer. It drives the S_* request lines and the rb_*
//            stream, and receives the read data, DataRdy and rb_ready.
//   slave  : the environment, i.e. the accelerator memory port plus the stream sink.
interface bsort_run_sequencer_if;
  logic [1:0]   S_oe_ram;
  logic [1:0]   S_we_ram;
  logic [17:0]  S_addr_ram;
  logic [127:0] S_Wdata_ram;
  logic [13:0]  S_data_ram_size;
  logic [127:0] Sout_Rdata_ram;
  logic [1:0]   Sout_DataRdy;
  logic         rb_valid;
  logic         rb_ready;
  logic [31:0]  rb_data;
  logic [7:0]   rb_index;

  modport master (
    output S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
    output rb_valid, rb_data, rb_index,
    input  Sout_Rdata_ram, Sout_DataRdy, rb_ready
  );

  modport slave (
    input  S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
    input  rb_valid, rb_data, rb_index,
    output Sout_Rdata_ram, Sout_DataRdy, rb_ready
  );
endinterface

// File: rtl/bsort_run_sequencer.sv
// bsort_run_sequencer
// Run controller for the HLS `main` sort accelerator. It does the following:
//   - pulses start_port for one cycle and counts cycles until done_port;
//   - reads RB_WORDS result words back over the channel-0 slave read port;
//   - streams the result words out on a valid/ready interface.
// Ports:
//   clock, reset          : clock, and an asynchronous active-low reset
//   cmd_start / cmd_busy  : launch request, and busy while a run is active
//   start_port, done_port : accelerator start and done handshake
//   bus (master)          : slave memory read port plus the rb_* readback stream
//   run_cycles            : cycle count of the last run (the start cycle counts as 1)
//   status_*              : sticky outcome flags, cleared by the next accepted start
// Every output comes straight from a flop. The output flops are loaded from
// the next-state decode, so each output changes on the same edge as the FSM.
module bsort_run_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 200000000,
  parameter int unsigned RB_WORDS       = 32,
  parameter int unsigned RB_BASE        = 0,
  parameter int unsigned RB_RDY_LIMIT   = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cmd_start,
  output logic                         cmd_busy,
  output logic                         start_port,
  input  logic                         done_port,
  bsort_run_sequencer_if.master        bus,
  output logic [31:0]                  run_cycles,
  output logic                         status_done,
  output logic                         status_timeout,
  output logic                         status_rberr
);

  localparam logic [31:0] TO_LIM   = 32'(TIMEOUT_CYCLES);
  localparam logic [7:0]  LAST_IDX = 8'(RB_WORDS - 1);
  localparam logic [8:0]  BASE     = 9'(RB_BASE);
  localparam logic [31:0] RDY_LAST = 32'(RB_RDY_LIMIT - 1);

  typedef enum logic [2:0] {
    IDLE, START, WAIT_DONE, RB_REQ, RB_OUT, FINISH, TIMEOUT, RBERR
  } state_t;

  state_t      state, state_nxt;
  logic        rdy, hs, last;
  logic [31:0] cyc_inc;
  logic [8:0]  rd_addr, rd_addr_nxt;
  logic [7:0]  widx;
  logic [31:0] wcnt;
  logic        oe_q, rb_valid_q;
  logic [8:0]  addr_q;
  logic [6:0]  size_q;
  logic [31:0] rb_data_q;
  logic [7:0]  rb_index_q;
  logic        unused_ok;

  assign rdy     = bus.Sout_DataRdy[0];
  assign hs      = (state == RB_OUT) && bus.rb_ready;
  assign last    = (widx == LAST_IDX);
  assign cyc_inc = run_cycles + 32'd1;

  // Only channel 0 and the low read-data word are used.
  assign unused_ok = ^{bus.Sout_Rdata_ram[127:32], bus.Sout_DataRdy[1]};

  assign bus.S_oe_ram        = {1'b0, oe_q};
  assign bus.S_we_ram        = 2'b00;
  assign bus.S_addr_ram      = {9'd0, addr_q};
  assign bus.S_Wdata_ram     = '0;
  assign bus.S_data_ram_size = {7'd0, size_q};
  assign bus.rb_valid        = rb_valid_q;
  assign bus.rb_data         = rb_data_q;
  assign bus.rb_index        = rb_index_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (cmd_start) state_nxt = START;
      // The start cycle already counts as 1, so a limit of 1 ends the run here.
      START:     if (done_port)           state_nxt = RB_REQ;
                 else if (TO_LIM <= 32'd1) state_nxt = TIMEOUT;
                 else                     state_nxt = WAIT_DONE;
      // If done arrives on the cycle that reaches the limit, done wins.
      WAIT_DONE: if (done_port)             state_nxt = RB_REQ;
                 else if (cyc_inc >= TO_LIM) state_nxt = TIMEOUT;
      RB_REQ:    if (rdy)                   state_nxt = RB_OUT;
                 else if (wcnt >= RDY_LAST) state_nxt = RBERR;
      RB_OUT:    if (bus.rb_ready) state_nxt = last ? FINISH : RB_REQ;
      FINISH, TIMEOUT, RBERR: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // The read address rewinds to the base while idle and advances by one word
  // on each readback handshake.
  always_comb begin
    rd_addr_nxt = rd_addr;
    if (state == IDLE) rd_addr_nxt = BASE;
    else if (hs)       rd_addr_nxt = rd_addr + 9'd4;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      start_port     <= 1'b0;
      cmd_busy       <= 1'b0;
      oe_q           <= 1'b0;
      addr_q         <= '0;
      size_q         <= '0;
      rd_addr        <= '0;
      widx           <= '0;
      wcnt           <= '0;
      rb_valid_q     <= 1'b0;
      rb_data_q      <= '0;
      rb_index_q     <= '0;
      run_cycles     <= '0;
      status_done    <= 1'b0;
      status_timeout <= 1'b0;
      status_rberr   <= 1'b0;
    end else begin
      start_port <= (state_nxt == START);
      cmd_busy   <= state_nxt inside {START, WAIT_DONE, RB_REQ, RB_OUT};
      oe_q       <= (state_nxt == RB_REQ);
      addr_q     <= (state_nxt == RB_REQ) ? rd_addr_nxt : 9'd0;
      size_q     <= (state_nxt == RB_REQ) ? 7'd32 : 7'd0;
      rb_valid_q <= (state_nxt == RB_OUT);
      rd_addr    <= rd_addr_nxt;
      // Per-request DataRdy wait counter; it is zero on the first RB_REQ cycle.
      wcnt       <= (state == RB_REQ) ? wcnt + 32'd1 : 32'd0;

      case (state)
        IDLE: begin
          widx <= '0;
          if (cmd_start) begin
            run_cycles     <= '0;
            status_done    <= 1'b0;
            status_timeout <= 1'b0;
            status_rberr   <= 1'b0;
          end
        end
        START:     run_cycles <= 32'd1;
        WAIT_DONE: run_cycles <= (state_nxt == TIMEOUT) ? TO_LIM : cyc_inc;
        RB_REQ: begin
          if (rdy) rb_data_q <= bus.Sout_Rdata_ram[31:0];
          // On a DataRdy timeout, rb_index records the word that failed.
          if (rdy || state_nxt == RBERR) rb_index_q <= widx;
        end
        RB_OUT: if (bus.rb_ready && !last) widx <= widx + 8'd1;
        default: ;
      endcase

      if (state_nxt == FINISH)  status_done    <= 1'b1;
      if (state_nxt == TIMEOUT) status_timeout <= 1'b1;
      if (state_nxt == RBERR)   status_rberr   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bsort_run_sequencer.sv
module tb_bsort_run_sequencer;
  localparam int TO  = 50;
  localparam int NW  = 4;
  localparam int LIM = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_start = 1'b0;
  logic        done_port = 1'b0;
  logic        cmd_busy, start_port, status_done, status_timeout, status_rberr;
  logic [31:0] run_cycles;
  logic [31:0] mem [128];

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  bsort_run_sequencer_if bus ();

  bsort_run_sequencer #(
    .TIMEOUT_CYCLES(TO), .RB_WORDS(NW), .RB_BASE(0), .RB_RDY_LIMIT(LIM)
  ) dut (
    .clock(clock), .reset(reset), .cmd_start(cmd_start), .cmd_busy(cmd_busy),
    .start_port(start_port), .done_port(done_port), .bus(bus),
    .run_cycles(run_cycles), .status_done(status_done),
    .status_timeout(status_timeout), .status_rberr(status_rberr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({start_port, cmd_busy, bus.S_oe_ram, bus.rb_valid}), 64'(0));
    chk({tag, "_flags"}, 64'({status_done, status_timeout, status_rberr}), 64'(0));
    chk({tag, "_cycles"}, 64'(run_cycles), 64'(0));
    chk({tag, "_bus"}, 64'({bus.S_addr_ram, bus.S_data_ram_size, bus.rb_index}), 64'(0));
    chk({tag, "_data"}, 64'(bus.rb_data), 64'(0));
  endtask

  // One run, checked against outcomes that are derived from the rules alone.
  //   d     : first cycle (after the start cycle) with done high; -1 = never
  //   rdly  : DataRdy arrives when the request has been pending rdly cycles
  //   err_w : word whose DataRdy is withheld (-1 = none)
  //   stall : word whose rb_ready is held low for 7 cycles (-1 = none)
  task automatic run(input int d, input int rdly, input int err_w, input int stall,
                     input bit busy_start, input bit rnd_ready);
    int cyc, first_oe, hs, hs_cyc, rdy_cyc, age, err_oe, stall_cyc, n_valid, exp_words;
    bit to_exp, prev_oe, held, ended;
    logic [31:0] pdata;
    logic [7:0]  pidx;
    logic [2:0]  ef;
    first_oe = -1; hs = 0; hs_cyc = -1; rdy_cyc = -1; age = 0; err_oe = 0;
    stall_cyc = 0; n_valid = 0; prev_oe = 0; held = 0; ended = 0;
    pdata = '0; pidx = '0;
    for (int k = 0; k < 128; k++) mem[k] = $urandom;
    to_exp    = (d < 0) || (d + 1 > TO);
    exp_words = to_exp ? 0 : ((err_w >= 0) ? err_w : NW);
    ef        = {!to_exp && err_w < 0, to_exp, !to_exp && err_w >= 0};

    @(negedge clock); cmd_start = 1'b1;
    @(negedge clock); cmd_start = 1'b0;
    chk("start_pulse", 64'(start_port), 64'(1));
    chk("busy_rise", 64'(cmd_busy), 64'(1));
    chk("clr_flags", 64'({status_done, status_timeout, status_rberr}), 64'(0));
    chk("clr_cycles", 64'(run_cycles), 64'(0));

    for (cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) begin
        @(negedge clock);
        chk("start_once", 64'(start_port), 64'(0));
        if (!cmd_busy) begin ended = 1; break; end
      end
      if (bus.S_oe_ram[0]) begin
        if (!prev_oe) begin
          age = 0;
          if (first_oe < 0) first_oe = cyc;
          chk("rd_addr", 64'(bus.S_addr_ram), 64'((4 * hs) % 512));
          if (hs > 0) chk("hs_to_oe", 64'(cyc), 64'(hs_cyc + 1));
        end
        if (hs == err_w) err_oe++;
        chk("rd_size", 64'(bus.S_data_ram_size), 64'(32));
      end else begin
        chk("size_idle", 64'(bus.S_data_ram_size), 64'(0));
      end
      chk("oe_excl_valid", 64'(bus.S_oe_ram[0] & bus.rb_valid), 64'(0));
      chk("const_bus", 64'({bus.S_oe_ram[1], bus.S_we_ram, |bus.S_Wdata_ram}), 64'(0));

      if (bus.rb_valid) begin
        n_valid++;
        if (held) begin
          chk("hold_data", 64'(bus.rb_data), 64'(pdata));
          chk("hold_idx", 64'(bus.rb_index), 64'(pidx));
        end else begin
          chk("rdy_to_valid", 64'(cyc), 64'(rdy_cyc + 1));
          chk("rb_idx", 64'(bus.rb_index), 64'(hs));
          chk("rb_data", 64'(bus.rb_data), 64'(mem[((4 * hs) % 512) / 4]));
        end
        pdata = bus.rb_data;
        pidx  = bus.rb_index;
        if (hs == stall) begin
          bus.rb_ready = (stall_cyc >= 7);
          stall_cyc++;
        end else begin
          bus.rb_ready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
        end
        if (bus.rb_ready) begin held = 0; hs++; hs_cyc = cyc; end
        else held = 1;
      end else begin
        bus.rb_ready = 1'($urandom_range(1));
      end

      // Memory port responder; DataRdy noise while no read is pending.
      if (bus.S_oe_ram[0]) begin
        bus.Sout_DataRdy = {1'($urandom_range(1)), 1'(age == rdly && hs != err_w)};
        if (bus.Sout_DataRdy[0]) rdy_cyc = cyc;
        bus.Sout_Rdata_ram = {$urandom, $urandom, $urandom,
                              bus.Sout_DataRdy[0] ? mem[bus.S_addr_ram[8:2]] : $urandom};
        age++;
      end else begin
        bus.Sout_DataRdy   = 2'($urandom_range(3));
        bus.Sout_Rdata_ram = {$urandom, $urandom, $urandom, $urandom};
      end

      done_port = (d >= 0) && (cyc == d || (cyc > d && $urandom_range(1) == 1));
      cmd_start = busy_start && (cyc == 3);
      prev_oe   = bus.S_oe_ram[0];
    end
    cmd_start = 1'b0;
    done_port = 1'b0;

    chk("run_ends", 64'(ended), 64'(1));
    chk("flags", 64'({status_done, status_timeout, status_rberr}), 64'(ef));
    chk("run_cycles", 64'(run_cycles), 64'(to_exp ? TO : d + 1));
    chk("words", 64'(hs), 64'(exp_words));
    chk("valid_end", 64'(bus.rb_valid), 64'(0));
    if (to_exp) begin
      chk("to_no_oe", 64'(first_oe), 64'(-1));
      chk("to_no_valid", 64'(n_valid), 64'(0));
    end else begin
      chk("done_to_oe", 64'(first_oe), 64'(d + 1));
    end
    if (!to_exp && err_w >= 0) begin
      chk("err_oe_cycles", 64'(err_oe), 64'(LIM));
      chk("err_idx", 64'(bus.rb_index), 64'(err_w));
    end
    if (!to_exp && stall >= 0 && (err_w < 0 || stall < err_w))
      chk("stall_cycles", 64'(stall_cyc), 64'(8));
    repeat (3) @(negedge clock);
    chk("sticky_flags", 64'({status_done, status_timeout, status_rberr}), 64'(ef));
    chk("sticky_cycles", 64'(run_cycles), 64'(to_exp ? TO : d + 1));
    chk("idle_busy", 64'({cmd_busy, bus.S_oe_ram[0]}), 64'(0));
  endtask

  // Launch a run, let it sit n cycles past the start, then reset it mid-cycle.
  task automatic rst_mid(input int n, input string tag);
    @(negedge clock); cmd_start = 1'b1;
    @(negedge clock); cmd_start = 1'b0;
    repeat (n) @(negedge clock);
    if (n > 0) chk({tag, "_pre"}, 64'(run_cycles), 64'(n));
    #2 reset = 1'b0;
    #1 chk_zero(tag);
    @(negedge clock); reset = 1'b1;
  endtask

  initial begin
    bus.rb_ready = 1'b0;
    bus.Sout_DataRdy = 2'b00;
    bus.Sout_Rdata_ram = '0;
    #22 chk_zero("reset");
    @(negedge clock); reset = 1'b1;
    @(negedge clock); chk_zero("post_reset");

    run(5, 2, -1, -1, 1'b0, 1'b0);    // basic readback of 4 words
    run(0, 2, -1, -1, 1'b0, 1'b0);    // done during the start cycle
    run(-1, 0, -1, -1, 1'b0, 1'b0);   // never done: timeout at 50
    run(3, 1, -1, 2, 1'b0, 1'b0);     // consumer stalls on word 2
    run(4, 2, 1, -1, 1'b0, 1'b0);     // DataRdy withheld on word 1
    run(49, LIM - 1, -1, -1, 1'b0, 1'b1); // last cycles before both limits
    run(50, 0, -1, -1, 1'b0, 1'b0);   // done one cycle too late
    rst_mid(0, "rst_start");
    rst_mid(4, "rst_wait");
    run(7, 3, -1, -1, 1'b1, 1'b1);    // clean rerun; cmd_start while busy
    for (int i = 0; i < 6; i++)
      run(int'($urandom_range(0, 48)), int'($urandom_range(0, LIM - 1)),
          ($urandom_range(3) == 0) ? int'($urandom_range(0, NW - 1)) : -1,
          int'($urandom_range(0, NW)) - 1, 1'($urandom_range(1)), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
